bit_serial_alu: RTL
===================

# bit_serial_alu

Multi-cycle ALU that evaluates a WIDTH-bit operation one bit per clock, LSB first, through a single 1-bit slice. It uses the same 4-bit ALUOp encoding and per-bit equations as the 1-bit ALU slice. It is the sequencing and control end of that slice interface: it latches operands, drives ainvert/binvert/op and the carry chain bit by bit, and returns the assembled word with flags under a start/done handshake. It serves area-constrained datapaths in the lab processor where a full ripple ALU is not wanted.

## Interface
- WIDTH, 64, operand/result width in bits; must be ≥ 2.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  in  1  request pulse; sampled only in IDLE.
- ALUOp  in  4  operation code:
  - [3] invert a.
  - [2] invert b; also the initial carry-in.
  - [1:0]: 00 AND, 01 OR, 10 ADD, 11 reserved.
- a  in  WIDTH  operand A; latched when start is accepted.
- b  in  WIDTH  operand B; latched when start is accepted.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse, high in DONE.
- Result  out  WIDTH  final result; held between completions.
- CarryOut  out  1  carry out of bit WIDTH-1 for ADD; 0 for every other op.
- Zero  out  1  high when Result == 0; registered together with Result.

## Operation
- States are IDLE, RUN and DONE.
- Reset state is IDLE. On reset: busy=0, done=0, Result=0, CarryOut=0, Zero=0, internal counter, carry and shift registers cleared.
- IDLE, start=1: latch a, b and ALUOp; cnt=0; carry=ALUOp[2]; go to RUN.
- IDLE, start=0: remain in IDLE.
- RUN, each cycle, at bit i=cnt:
  - ma = a[i]^ALUOp[3]; mb = b[i]^ALUOp[2].
  - Result bit for 00: ma&mb. For 01: ma|mb. For 10: ma^mb^carry. For 11: 0.
  - carry <= (ma&mb)|(ma&carry)|(mb&carry). The carry updates for every op; it is only reported for ADD.
  - The result bit shifts into the MSB of the shift register, which shifts right.
  - cnt increments.
- RUN, cnt==WIDTH-1: process the last bit, then go to DONE. On the same edge:
  - Result is loaded from the completed shift register.
  - CarryOut is loaded with the final carry if ALUOp[1:0]==10, else 0.
  - Zero is loaded with (completed word == 0).
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- start is ignored in RUN and DONE. It is not queued. A new start is accepted only on the first IDLE cycle or later.
- Changes to a, b or ALUOp after acceptance have no effect on the operation in flight.
- Result, CarryOut and Zero change only on the RUN→DONE edge or on reset. Intermediate bits are never visible on these outputs.
- Subtraction is ALUOp=0110 (b inverted, carry-in 1). NOR is 1100. NAND is 1101.
- All arithmetic is modulo 2^WIDTH. There is no overflow flag.

## Timing
- Define edge 0 as the edge that samples start=1 in IDLE.
- busy is high from after edge 0 until edge WIDTH.
- Bit i is processed on edge i+1.
- Result, CarryOut and Zero become valid after edge WIDTH.
- done is high in the cycle between edge WIDTH and edge WIDTH+1.
- Throughput is one operation per WIDTH+2 cycles, because start is next accepted at edge WIDTH+2.
- If start is held high continuously, the block restarts every WIDTH+2 cycles and re-latches the inputs at each acceptance.
- reset low on any edge, including mid-RUN or in DONE, forces the reset state on that edge. The aborted operation never asserts done. reset has priority over start.
- Outputs are driven directly from registers. There is no combinational path from any input to any output.

## Test plan
All scenarios use WIDTH=8 unless noted.
- ADD 0x7F + 0x01, ALUOp=0010 -> after 8 cycles Result=0x80, CarryOut=0, Zero=0. done pulses exactly once, 8 cycles after the start edge.
- SUB 0x05 - 0x05, ALUOp=0110 -> Result=0x00, CarryOut=1, Zero=1. Wrap case: ADD 0xFF + 0x01 -> Result=0x00, CarryOut=1, Zero=1.
- Logic ops:
  - AND 0xF0, 0x3C (0000) -> Result=0x30, CarryOut=0.
  - OR 0xF0, 0x0C (0001) -> Result=0xFC.
  - NOR 0x0F, 0xF0 (1100) -> Result=0x00, Zero=1.
  - Reserved op 0011 -> Result=0x00, CarryOut=0, Zero=1.
- Apply start again at cycles 2 and 8 with different operands, and change a, b and ALUOp mid-RUN -> the first result is unaffected and only one done is produced. A start on the cycle after done is accepted.
- Drop reset to 0 at cycle 4 of a RUN -> the next edge shows busy=0, done=0, Result=0, CarryOut=0, Zero=0 and state IDLE, and no done follows. A fresh ADD 3+4 then yields Result=0x07.
- WIDTH=64: SUB 0 - 1 -> Result=0xFFFF_FFFF_FFFF_FFFF, CarryOut=0, and done appears 64 cycles after the start edge.

Source files
------------

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: one 1-bit ALU slice is stepped LSB first across a WIDTH-bit
// operand pair, under a start/done handshake.
module bit_serial_alu #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUOp,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             Zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [3:0]         op_q;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic [WIDTH-1:0]   sreg;

  logic               ma;
  logic               mb;
  logic               res_bit;
  logic               carry_nxt;
  logic [WIDTH-1:0]   word;

  // Operands shift right as they are consumed, so the slice always reads bit 0.
  always_comb begin
    ma        = a_q[0] ^ op_q[3];
    mb        = b_q[0] ^ op_q[2];
    res_bit   = 1'b0;
    case (op_q[1:0])
      2'b00:   res_bit = ma & mb;
      2'b01:   res_bit = ma | mb;
      2'b10:   res_bit = ma ^ mb ^ carry;
      default: res_bit = 1'b0;
    endcase
    carry_nxt = (ma & mb) | (ma & carry) | (mb & carry);
    word      = {res_bit, sreg[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      sreg     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      Result   <= '0;
      CarryOut <= 1'b0;
      Zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= ALUOp;
            cnt   <= '0;
            carry <= ALUOp[2];
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          sreg  <= word;
          carry <= carry_nxt;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            Result   <= word;
            CarryOut <= (op_q[1:0] == 2'b10) ? carry_nxt : 1'b0;
            Zero     <= (word == '0);
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
